// File: rtl/poke_sequencer.sv
// Command FIFO and issue sequencer in front of the single-entry poke engine.
// Optional range check of row/entry on pop: define POKE_SEQ_RANGE_CHECK_EN.
module poke_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ROWS       = 4096,
    parameter int ENTRIES    = 64
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [95:0]                 AXIS_CMD_TDATA,
    input  logic                        AXIS_CMD_TVALID,
    output logic                        AXIS_CMD_TREADY,
    output logic [31:0]                 poke_row,
    output logic [31:0]                 poke_entry,
    output logic [31:0]                 poke_value,
    output logic                        poke_start,
    input  logic                        poke_busy,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic                        idle,
    output logic [31:0]                 done_count,
    output logic [31:0]                 reject_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ROWS < 1 || ENTRIES < 1) begin : g_param_check
        $error("poke_sequencer: FIFO_DEPTH must be a power of 2 >= 2, ROWS/ENTRIES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic [95:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [95:0]   head;
    logic          push, pop, issue, head_ok;

    // No bypass: a full FIFO refuses input even when popping this cycle.
    assign AXIS_CMD_TREADY = resetn & (count != (AW+1)'(FIFO_DEPTH));
    assign push            = AXIS_CMD_TVALID & AXIS_CMD_TREADY;
    assign head            = mem[rd_ptr];

`ifdef POKE_SEQ_RANGE_CHECK_EN
    assign head_ok = (head[31:0] < 32'(ROWS)) && (head[63:32] < 32'(ENTRIES));
`else
    assign head_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= AXIS_CMD_TDATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0 && !poke_busy) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        issue     = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            // Engine raises busy combinationally from start, so busy is not sampled here.
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!poke_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            poke_row   <= '0;
            poke_entry <= '0;
            poke_value <= '0;
            done_count <= '0;
        end else begin
            if (issue) begin
                poke_row   <= head[31:0];
                poke_entry <= head[63:32];
                poke_value <= head[95:64];
            end
            if (state == S_WAIT && !poke_busy) begin
                done_count <= done_count + 1'b1;
            end
        end
    end

`ifdef POKE_SEQ_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reject_count <= '0;
        end else if (pop && !head_ok) begin
            reject_count <= reject_count + 1'b1;
        end
    end
`else
    assign reject_count = '0;
`endif

    assign poke_start = (state == S_ISSUE);
    assign pending    = count;
    assign idle       = (state == S_IDLE) && (count == '0) && !poke_start;

endmodule

// File: tb/tb_poke_sequencer.sv
// Directed bench for poke_sequencer with a 6-cycle poke engine model.
module tb_poke_sequencer;

    localparam int BUSY_CYC = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [95:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [31:0] prow, pentry, pvalue;
    logic        pstart, pbusy;
    logic [4:0]  pending;
    logic        idle;
    logic [31:0] done_count, reject_count;

    logic        force_busy = 1'b0;
    int          eng_cnt;

    int          total = 0;
    int          bad = 0;
    logic [95:0] log_q [$];
    logic [95:0] cur = '0;
    int          stab_err = 0;
    int          gate_err = 0;
    int          rdy_err = 0;
    int          max_pend = 0;

    poke_sequencer #(
        .FIFO_DEPTH(16),
        .ROWS(4096),
        .ENTRIES(64)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .AXIS_CMD_TDATA(tdata),
        .AXIS_CMD_TVALID(tvalid),
        .AXIS_CMD_TREADY(tready),
        .poke_row(prow),
        .poke_entry(pentry),
        .poke_value(pvalue),
        .poke_start(pstart),
        .poke_busy(pbusy),
        .pending(pending),
        .idle(idle),
        .done_count(done_count),
        .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    // Engine: busy is high in the start cycle and the following BUSY_CYC-1 cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)            eng_cnt <= 0;
        else if (pstart)        eng_cnt <= BUSY_CYC - 1;
        else if (eng_cnt != 0)  eng_cnt <= eng_cnt - 1;
    end
    assign pbusy = force_busy | pstart | (eng_cnt != 0);

    always @(negedge clk) begin
        if (resetn) begin
            if (pstart) begin
                log_q.push_back({pvalue, pentry, prow});
                cur = {pvalue, pentry, prow};
                if (force_busy || eng_cnt != 0) gate_err++;
            end else if (eng_cnt != 0 && {pvalue, pentry, prow} != cur) begin
                stab_err++;
            end
            if (int'(pending) > max_pend) max_pend = int'(pending);
            if ((pending == 5'd16) == tready) rdy_err++;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] r, input logic [31:0] e, input logic [31:0] v);
        int t = 0;
        tdata  = {v, e, r};
        tvalid = 1'b1;
        while (!tready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("push_timeout", {95'd0, tready}, 96'd1);
        @(posedge clk);
        tick();
        tvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] target);
        int t = 0;
        while (done_count != target && t < 2000) begin
            tick();
            t++;
        end
        check(tag, {64'd0, done_count}, {64'd0, target});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tready"},  {95'd0, tready},  96'd0);
        check({tag, "_pending"}, {91'd0, pending}, 96'd0);
        check({tag, "_start"},   {95'd0, pstart},  96'd0);
        check({tag, "_idle"},    {95'd0, idle},    96'd1);
        check({tag, "_done"},    {64'd0, done_count},   96'd0);
        check({tag, "_reject"},  {64'd0, reject_count}, 96'd0);
        check({tag, "_cmd"},     {pvalue, pentry, prow}, 96'd0);
    endtask

    initial begin
        int base;
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        // Reset values
        repeat (3) tick();
        check_reset_state("rst");
        resetn = 1'b1;
        tick();

        // Single command: start visible after the edge following the accepting edge
        base = log_q.size();
        push_cmd(32'd5, 32'd17, 32'hDEADBEEF);
        check("single_pend1", {91'd0, pending}, 96'd1);
        check("single_nostart", {95'd0, pstart}, 96'd0);
        tick();
        check("single_start", {95'd0, pstart}, 96'd1);
        check("single_cmd", {pvalue, pentry, prow}, {32'hDEADBEEF, 32'd17, 32'd5});
        check("single_busy_idle", {95'd0, idle}, 96'd0);
        wait_done("single_done", 32'd1);
        check("single_idle", {95'd0, idle}, 96'd1);
        check("single_nstart", log_q.size() - base, 96'd1);

        // Burst of 20 into a 16-deep FIFO
        base = log_q.size();
        max_pend = 0;
        for (int i = 0; i < 20; i++) push_cmd(32'd100 + i, i, 32'hA000_0000 + i);
        wait_done("burst_done", 32'd21);
        check("burst_maxpend", max_pend, 96'd16);
        check("burst_nstart", log_q.size() - base, 96'd20);
        if (log_q.size() >= base + 20)
            for (int i = 0; i < 20; i++)
                check("burst_order", log_q[base+i], {32'hA000_0000 + i, 32'(i), 32'd100 + i});
        check("burst_tready", rdy_err, 96'd0);

        // Start gating by external busy
        force_busy = 1'b1;
        base = log_q.size();
        for (int i = 0; i < 3; i++) push_cmd(32'd300 + i, 32'd3 + i, 32'hC0 + i);
        repeat (50) tick();
        check("gate_nstart", log_q.size() - base, 96'd0);
        check("gate_pend", {91'd0, pending}, 96'd3);
        force_busy = 1'b0;
        wait_done("gate_done", 32'd24);
        if (log_q.size() >= base + 3)
            for (int i = 0; i < 3; i++)
                check("gate_order", log_q[base+i], {32'hC0 + i, 32'd3 + i, 32'd300 + i});
        check("gate_err", gate_err, 96'd0);

        // Push and pop on the same edge at pending=1
        force_busy = 1'b1;
        base = log_q.size();
        push_cmd(32'd400, 32'd1, 32'hD00);
        check("coll_pend_pre", {91'd0, pending}, 96'd1);
        tdata  = {32'hD01, 32'd2, 32'd401};
        tvalid = 1'b1;
        force_busy = 1'b0;
        @(posedge clk);
        tick();
        tvalid = 1'b0;
        check("coll_pend", {91'd0, pending}, 96'd1);
        check("coll_start", {95'd0, pstart}, 96'd1);
        check("coll_cmd", {pvalue, pentry, prow}, {32'hD00, 32'd1, 32'd400});
        wait_done("coll_done", 32'd26);
        if (log_q.size() >= base + 2)
            check("coll_second", log_q[base+1], {32'hD01, 32'd2, 32'd401});

        // Range check
        base = log_q.size();
        push_cmd(32'd4096, 32'd0, 32'hE0);
        push_cmd(32'd0, 32'd64, 32'hE1);
        push_cmd(32'd1, 32'd2, 32'hE2);
`ifdef POKE_SEQ_RANGE_CHECK_EN
        wait_done("range_done", 32'd27);
        check("range_reject", {64'd0, reject_count}, 96'd2);
        check("range_nstart", log_q.size() - base, 96'd1);
        if (log_q.size() >= base + 1)
            check("range_cmd", log_q[base], {32'hE2, 32'd2, 32'd1});
`else
        wait_done("range_done", 32'd29);
        check("range_reject", {64'd0, reject_count}, 96'd0);
        check("range_nstart", log_q.size() - base, 96'd3);
        if (log_q.size() >= base + 3) begin
            check("range_cmd0", log_q[base],   {32'hE0, 32'd0, 32'd4096});
            check("range_cmd1", log_q[base+1], {32'hE1, 32'd64, 32'd0});
            check("range_cmd2", log_q[base+2], {32'hE2, 32'd2, 32'd1});
        end
`endif
        check("stab_err", stab_err, 96'd0);

        // Async reset while in WAIT with 4 queued
        for (int i = 0; i < 5; i++) push_cmd(32'd500 + i, i, 32'hB0 + i);
        check("ar_pend", {91'd0, pending}, 96'd4);
        check("ar_busy_idle", {95'd0, idle}, 96'd0);
        resetn = 1'b0;
        #1;
        check_reset_state("ar");
        tick();
        resetn = 1'b1;
        base = log_q.size();
        repeat (20) tick();
        check("ar_nostart", log_q.size() - base, 96'd0);
        check("ar_idle", {95'd0, idle}, 96'd1);
        push_cmd(32'd7, 32'd8, 32'hF00D);
        wait_done("ar_new_done", 32'd1);
        if (log_q.size() >= base + 1)
            check("ar_new_cmd", log_q[base], {32'hF00D, 32'd8, 32'd7});
        check("ar_new_count", log_q.size() - base, 96'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
